// File: rtl/seq_player.sv
// Pattern-memory playback engine.
// A small register-file pattern memory is loaded while idle, then replayed one
// entry per clock onto dataOut, optionally wrapping, until the length runs out
// or a stop request aborts it.
//
// Stream semantics: valid=1 means dataOut/index carry a pattern entry in this
// cycle. There is no back-pressure; every entry is shown for exactly one cycle.
// When valid=0, dataOut and index are forced to 0.
//
// stateDbg exposes the FSM encoding for observation: 0=IDLE, 1=PLAY, 2=DONE.
module seq_player #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [3:0]       len,
  input  logic             loop,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] dataOut,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    index,
  output logic [1:0]       stateDbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           stateNext;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             memWe;

  logic [3:0]       lenQ;
  logic             loopQ;
  logic [3:0]       lenNext;
  logic             loopNext;
  logic [3:0]       lenEff;

  logic [WIDTH-1:0] dataNext;
  logic             validNext;
  logic             busyNext;
  logic             doneNext;
  logic [AW-1:0]    indexNext;
  logic [AW-1:0]    lastIdx;
  logic [AW-1:0]    incIdx;

  // Requested lengths beyond the memory size play the whole memory.
  assign lenEff   = (len > 4'(DEPTH)) ? 4'(DEPTH) : len;
  // lenQ is never 0 while in PLAY, so lenQ-1 is a valid address.
  assign lastIdx  = AW'(lenQ - 4'd1);
  assign incIdx   = index + AW'(1);
  assign stateDbg = state;

  // Pattern memory: cleared by reset, writable only while idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (memWe) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // State, latched playback settings and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      lenQ    <= '0;
      loopQ   <= 1'b0;
      dataOut <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      index   <= '0;
    end else begin
      state   <= stateNext;
      lenQ    <= lenNext;
      loopQ   <= loopNext;
      dataOut <= dataNext;
      valid   <= validNext;
      busy    <= busyNext;
      done    <= doneNext;
      index   <= indexNext;
    end
  end

  // Next-state and next-output decode; defaults describe the quiet (invalid) stream.
  always_comb begin
    stateNext = state;
    lenNext   = lenQ;
    loopNext  = loopQ;
    memWe     = 1'b0;
    dataNext  = '0;
    validNext = 1'b0;
    busyNext  = 1'b0;
    doneNext  = 1'b0;
    indexNext = '0;

    unique case (state)
      IDLE: begin
        memWe = wr_en;
        if (start) begin
          if (lenEff == 4'd0) begin
            stateNext = DONE;
            doneNext  = 1'b1;
          end else begin
            stateNext = PLAY;
            lenNext   = lenEff;
            loopNext  = loop;
            validNext = 1'b1;
            busyNext  = 1'b1;
            indexNext = '0;
            // A same-cycle write to entry 0 is forwarded so the first entry
            // shows the freshly written value.
            dataNext  = (wr_en && (wr_addr == '0)) ? wr_data : mem[0];
          end
        end
      end

      PLAY: begin
        if (stop) begin
          stateNext = DONE;
          doneNext  = 1'b1;
        end else if (index == lastIdx) begin
          if (loopQ) begin
            validNext = 1'b1;
            busyNext  = 1'b1;
            indexNext = '0;
            dataNext  = mem[0];
          end else begin
            stateNext = DONE;
            doneNext  = 1'b1;
          end
        end else begin
          validNext = 1'b1;
          busyNext  = 1'b1;
          indexNext = incIdx;
          dataNext  = mem[incIdx];
        end
      end

      DONE: begin
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player: one task per scenario, inline comparisons,
// expected stream values come from a hand-written pattern and an expected queue.
module tb_seq_player;

  localparam int W = 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic         clock = 1'b0;
  logic         reset;
  logic         wr_en;
  logic [2:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic [3:0]   len;
  logic         loop;
  logic         start;
  logic         stop;
  logic [W-1:0] dataOut;
  logic         valid;
  logic         busy;
  logic         done;
  logic [2:0]   index;
  logic [1:0]   stateDbg;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] pattern [8];
  logic [W-1:0] expQ [$];
  logic [W-1:0] expData;

  seq_player #(.WIDTH(W), .DEPTH(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .len     (len),
    .loop    (loop),
    .start   (start),
    .stop    (stop),
    .dataOut (dataOut),
    .valid   (valid),
    .busy    (busy),
    .done    (done),
    .index   (index),
    .stateDbg(stateDbg)
  );

  // Clock and reset
  always #5 clock = ~clock;

  // Advance one edge; inputs are driven and outputs sampled 1ns after the edge.
  task automatic stepClk();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] snap();
    return {stateDbg, valid, busy, done, index, dataOut};
  endfunction

  function automatic logic [15:0] expv(input logic [1:0] st, input logic v, input logic b,
                                       input logic d, input logic [2:0] idx, input logic [W-1:0] data);
    return {st, v, b, d, idx, data};
  endfunction

  // Driver tasks
  task automatic loadPattern();
    wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_addr = 3'(i);
      wr_data = pattern[i];
      stepClk();
    end
    wr_en = 1'b0;
  endtask

  task automatic startPlay(input logic [3:0] l, input logic lp);
    len   = l;
    loop  = lp;
    start = 1'b1;
    stepClk();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stepClk();
    stepClk();
    checks++;
    if (snap() !== expv(ST_IDLE, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_state got %h expected %h", snap(), expv(ST_IDLE, 0, 0, 0, 0, 0));
    end
    reset = 1'b0;
    stepClk();
  endtask

  task automatic test_full_play();
    for (int i = 0; i < 8; i++) expQ.push_back(pattern[i]);
    startPlay(4'd8, 1'b0);
    for (int k = 0; k < 8; k++) begin
      expData = expQ.pop_front();
      checks++;
      if (snap() !== expv(ST_PLAY, 1, 1, 0, 3'(k), expData)) begin
        errors++;
        $display("FAIL full_play k=%0d got %h expected %h", k, snap(), expv(ST_PLAY, 1, 1, 0, 3'(k), expData));
      end
      stepClk();
    end
    checks++;
    if (snap() !== expv(ST_DONE, 0, 0, 1, 0, 0)) begin
      errors++;
      $display("FAIL full_done got %h expected %h", snap(), expv(ST_DONE, 0, 0, 1, 0, 0));
    end
    stepClk();
    checks++;
    if (snap() !== expv(ST_IDLE, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL full_idle got %h expected %h", snap(), expv(ST_IDLE, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_loop_stop();
    logic [2:0] expIdx [7];
    expIdx = '{0, 1, 2, 0, 1, 2, 0};
    for (int k = 0; k < 7; k++) expQ.push_back(pattern[expIdx[k]]);
    startPlay(4'd3, 1'b1);
    for (int k = 0; k < 7; k++) begin
      expData = expQ.pop_front();
      checks++;
      if (snap() !== expv(ST_PLAY, 1, 1, 0, expIdx[k], expData)) begin
        errors++;
        $display("FAIL loop_stop k=%0d got %h expected %h", k, snap(), expv(ST_PLAY, 1, 1, 0, expIdx[k], expData));
      end
      if (k == 6) stop = 1'b1;
      stepClk();
    end
    stop = 1'b0;
    checks++;
    if (snap() !== expv(ST_DONE, 0, 0, 1, 0, 0)) begin
      errors++;
      $display("FAIL loop_stop_done got %h expected %h", snap(), expv(ST_DONE, 0, 0, 1, 0, 0));
    end
    stepClk();
    checks++;
    if (snap() !== expv(ST_IDLE, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL loop_stop_idle got %h expected %h", snap(), expv(ST_IDLE, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_len_zero();
    startPlay(4'd0, 1'b1);
    checks++;
    if (snap() !== expv(ST_DONE, 0, 0, 1, 0, 0)) begin
      errors++;
      $display("FAIL len_zero_done got %h expected %h", snap(), expv(ST_DONE, 0, 0, 1, 0, 0));
    end
    stepClk();
    checks++;
    if (snap() !== expv(ST_IDLE, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL len_zero_idle got %h expected %h", snap(), expv(ST_IDLE, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_len_clamp();
    startPlay(4'd15, 1'b0);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (snap() !== expv(ST_PLAY, 1, 1, 0, 3'(k), pattern[k])) begin
        errors++;
        $display("FAIL len_clamp k=%0d got %h expected %h", k, snap(), expv(ST_PLAY, 1, 1, 0, 3'(k), pattern[k]));
      end
      stepClk();
    end
    checks++;
    if (snap() !== expv(ST_DONE, 0, 0, 1, 0, 0)) begin
      errors++;
      $display("FAIL len_clamp_done got %h expected %h", snap(), expv(ST_DONE, 0, 0, 1, 0, 0));
    end
    stepClk();
  endtask

  task automatic test_write_in_play();
    startPlay(4'd8, 1'b0);
    wr_en   = 1'b1;
    wr_addr = 3'd2;
    wr_data = 8'hFF;
    for (int k = 0; k < 8; k++) stepClk();
    // Now in DONE: a write here must be ignored as well.
    wr_addr = 3'd3;
    wr_data = 8'hEE;
    stepClk();
    wr_en = 1'b0;
    startPlay(4'd4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (snap() !== expv(ST_PLAY, 1, 1, 0, 3'(k), pattern[k])) begin
        errors++;
        $display("FAIL write_in_play k=%0d got %h expected %h", k, snap(), expv(ST_PLAY, 1, 1, 0, 3'(k), pattern[k]));
      end
      stepClk();
    end
    checks++;
    if (snap() !== expv(ST_DONE, 0, 0, 1, 0, 0)) begin
      errors++;
      $display("FAIL write_in_play_done got %h expected %h", snap(), expv(ST_DONE, 0, 0, 1, 0, 0));
    end
    stepClk();
  endtask

  task automatic test_write_start_same();
    wr_en   = 1'b1;
    wr_addr = 3'd0;
    wr_data = 8'h5A;
    startPlay(4'd1, 1'b0);
    wr_en = 1'b0;
    checks++;
    if (snap() !== expv(ST_PLAY, 1, 1, 0, 0, 8'h5A)) begin
      errors++;
      $display("FAIL write_start_fwd got %h expected %h", snap(), expv(ST_PLAY, 1, 1, 0, 0, 8'h5A));
    end
    stepClk();
    checks++;
    if (snap() !== expv(ST_DONE, 0, 0, 1, 0, 0)) begin
      errors++;
      $display("FAIL write_start_done got %h expected %h", snap(), expv(ST_DONE, 0, 0, 1, 0, 0));
    end
    stepClk();
    wr_en   = 1'b1;
    wr_addr = 3'd0;
    wr_data = pattern[0];
    stepClk();
    wr_en = 1'b0;
  endtask

  task automatic test_stop_priority();
    startPlay(4'd2, 1'b1);
    stepClk();
    checks++;
    if (snap() !== expv(ST_PLAY, 1, 1, 0, 1, pattern[1])) begin
      errors++;
      $display("FAIL stop_prio_last got %h expected %h", snap(), expv(ST_PLAY, 1, 1, 0, 1, pattern[1]));
    end
    stop = 1'b1;
    stepClk();
    stop = 1'b0;
    checks++;
    if (snap() !== expv(ST_DONE, 0, 0, 1, 0, 0)) begin
      errors++;
      $display("FAIL stop_prio_done got %h expected %h", snap(), expv(ST_DONE, 0, 0, 1, 0, 0));
    end
    stepClk();
  endtask

  task automatic test_stop_idle();
    stop = 1'b1;
    stepClk();
    stepClk();
    checks++;
    if (snap() !== expv(ST_IDLE, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL stop_idle got %h expected %h", snap(), expv(ST_IDLE, 0, 0, 0, 0, 0));
    end
    startPlay(4'd2, 1'b0);
    stop = 1'b0;
    checks++;
    if (snap() !== expv(ST_PLAY, 1, 1, 0, 0, pattern[0])) begin
      errors++;
      $display("FAIL start_over_stop got %h expected %h", snap(), expv(ST_PLAY, 1, 1, 0, 0, pattern[0]));
    end
    stepClk();
    stepClk();
    checks++;
    if (snap() !== expv(ST_DONE, 0, 0, 1, 0, 0)) begin
      errors++;
      $display("FAIL start_over_stop_done got %h expected %h", snap(), expv(ST_DONE, 0, 0, 1, 0, 0));
    end
    stepClk();
  endtask

  task automatic test_restart_ignored();
    startPlay(4'd8, 1'b0);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (snap() !== expv(ST_PLAY, 1, 1, 0, 3'(k), pattern[k])) begin
        errors++;
        $display("FAIL restart_ign k=%0d got %h expected %h", k, snap(), expv(ST_PLAY, 1, 1, 0, 3'(k), pattern[k]));
      end
      if (k >= 1) start = 1'b1;
      stepClk();
    end
    // start is still high through the DONE cycle and must not restart.
    checks++;
    if (snap() !== expv(ST_DONE, 0, 0, 1, 0, 0)) begin
      errors++;
      $display("FAIL restart_ign_done got %h expected %h", snap(), expv(ST_DONE, 0, 0, 1, 0, 0));
    end
    stepClk();
    start = 1'b0;
    checks++;
    if (snap() !== expv(ST_IDLE, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL restart_ign_idle got %h expected %h", snap(), expv(ST_IDLE, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_reset_mid();
    startPlay(4'd8, 1'b0);
    stepClk();
    stepClk();
    stepClk();
    checks++;
    if (snap() !== expv(ST_PLAY, 1, 1, 0, 3, pattern[3])) begin
      errors++;
      $display("FAIL reset_mid_pre got %h expected %h", snap(), expv(ST_PLAY, 1, 1, 0, 3, pattern[3]));
    end
    reset = 1'b1;
    start = 1'b1;
    wr_en = 1'b1;
    stepClk();
    reset = 1'b0;
    start = 1'b0;
    wr_en = 1'b0;
    checks++;
    if (snap() !== expv(ST_IDLE, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_mid got %h expected %h", snap(), expv(ST_IDLE, 0, 0, 0, 0, 0));
    end
    stepClk();
    checks++;
    if (snap() !== expv(ST_IDLE, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_no_resume got %h expected %h", snap(), expv(ST_IDLE, 0, 0, 0, 0, 0));
    end
    startPlay(4'd8, 1'b0);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (snap() !== expv(ST_PLAY, 1, 1, 0, 3'(k), 8'h00)) begin
        errors++;
        $display("FAIL reset_cleared k=%0d got %h expected %h", k, snap(), expv(ST_PLAY, 1, 1, 0, 3'(k), 8'h00));
      end
      stepClk();
    end
    checks++;
    if (snap() !== expv(ST_DONE, 0, 0, 1, 0, 0)) begin
      errors++;
      $display("FAIL reset_cleared_done got %h expected %h", snap(), expv(ST_DONE, 0, 0, 1, 0, 0));
    end
    stepClk();
  endtask

  initial begin
    pattern = '{8'd1, 8'd3, 8'd12, 8'd20, 8'd18, 8'd7, 8'd4, 8'd11};
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    len     = '0;
    loop    = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    stepClk();

    test_reset();
    loadPattern();
    test_full_play();
    test_loop_stop();
    test_len_zero();
    test_len_clamp();
    test_write_in_play();
    test_write_start_same();
    test_stop_priority();
    test_stop_idle();
    test_restart_ignored();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
